mips_cpu_muldiv: RTL and testbench
==================================

Name: mips_cpu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core. It replaces single-cycle combinational HI/LO update with an iterative radix-2 engine and a busy/done handshake. It supports signed/unsigned MULT/DIV at configurable width, MTHI/MTLO writes, abort-on-reissue and defined divide-by-zero/overflow results. The core stalls MFHI/MFLO while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width; must be >= 4 and even
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
clock_enable  input  1  global advance enable; low freezes all state, outputs hold
start  input  1  issue strobe, sampled on rising clk when clock_enable=1
op  input  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
rs_val  input  WIDTH  first operand (dividend / multiplicand / MTHI-MTLO source)
rt_val  input  WIDTH  second operand (divisor / multiplier); ignored for MTHI/MTLO
busy  output  1  operation in flight; core stalls MFHI/MFLO while high
done  output  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset_n=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the operation; no partial HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start, op MULT/MULTU: latch |rs|,|rt| (abs only for MULT), record sign = rs[W-1]^rt[W-1]; go to MUL; busy=1 after the edge.
- IDLE + start, op DIV/DIVU: latch abs values (DIV only), record quotient sign = rs^rt MSBs and remainder sign = rs MSB; go to DIV.
- MTHI/MTLO with start: hi (resp. lo) <= rs_val at that edge; state -> IDLE; done stays 0.
- MUL: WIDTH shift-add steps, one per enabled edge; 2*WIDTH-bit accumulator.
- DIV: WIDTH restoring steps, one per enabled edge; quotient and remainder shift registers.
- Counter runs 0..WIDTH-1; on last step go to FIX.
- FIX, one edge: apply sign correction via two's complement; write hi/lo; state -> IDLE. busy drops and done=1 in the cycle after this edge; done clears the following cycle.
- Fixed latency: start edge N -> hi/lo valid and done=1 after edge N+WIDTH+1, i.e. 33 enabled edges for WIDTH=32.
- Mul result: hi = product[2W-1:W], lo = product[W-1:0].
- Div result: lo = quotient, hi = remainder; remainder takes the dividend's sign (truncating division).
- Divide by zero, both DIV and DIVU: lo = all ones, hi = rs_val. Same latency; no exception.
- Signed overflow, DIV of most-negative by -1: lo = most-negative, hi = 0.
- start while busy aborts the current op and starts the new one at that edge. MTHI/MTLO while busy aborts the op and performs the write; the aborted op never writes hi/lo.
- clock_enable=0: no state, counter, or hi/lo change. start is ignored that cycle. done holds its value.
- hi/lo are unchanged from the start edge until the FIX edge. Reads while busy return the old values; stalling on busy is the core's responsibility.

Decomposition:
- Package mips_cpu_muldiv_pkg: typedef enum muldiv_op_t (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5) and typedef enum muldiv_state_t (IDLE, MUL, DIV, FIX).
- The core decoder maps funct codes 011000/011001/011010/011011/010001/010011 to muldiv_op_t.
- Single module; no sub-module. The mul and div steps share the shift register and counter.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> busy=1 for 33 edges; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. hi/lo hold prior values until done.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, latency 33.
- Start DIVU 100/7; at edge 10 issue MULTU 3*4 -> result hi=0, lo=12, 33 edges after the second start. Start DIV; at edge 5 issue MTHI rs=0xA5 -> hi=0xA5, lo unchanged, no done.
- Start MULT, deassert reset_n asynchronously mid-cycle at edge 15 -> hi=lo=0 and busy=0 immediately. Toggle clock_enable low for 4 cycles mid-op -> latency extends exactly 4 cycles, result correct.

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes and engine states.
package mips_cpu_muldiv_pkg;

   localparam int unsigned OP_W = 3;

   // Decoder mapping: funct 011000/011001/011010/011011/010001/010011
   typedef enum logic [OP_W-1:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Core <-> muldiv unit bundle: issue request from the core, busy/done and HI/LO back.
interface mips_cpu_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   import mips_cpu_muldiv_pkg::*;

   logic             start;
   muldiv_op_t       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; one shared accumulator serves
// both the shift-add multiplier and the restoring divider, with sign fix-up at the end.
module mips_cpu_muldiv
   import mips_cpu_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic               clk,
   input logic               reset_n,
   input logic               clock_enable,
   mips_cpu_muldiv_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned ACC_W = 2 * WIDTH;

   muldiv_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             is_div_q, is_div_d;
   logic             div_zero_q, div_zero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] x);
      return ~x + ACC_W'(1);
   endfunction

   // Issue-side operand conditioning: magnitudes and recorded result signs
   logic             op_signed;
   logic             op_div;
   logic [WIDTH-1:0] rs_abs;
   logic [WIDTH-1:0] rt_abs;

   assign op_signed = (bus.op == MULT) || (bus.op == DIV);
   assign op_div    = (bus.op == DIV)  || (bus.op == DIVU);
   assign rs_abs    = (op_signed && bus.rs_val[WIDTH-1]) ? neg_w(bus.rs_val) : bus.rs_val;
   assign rt_abs    = (op_signed && bus.rt_val[WIDTH-1]) ? neg_w(bus.rt_val) : bus.rt_val;

   // Multiply step: acc = {partial product, remaining multiplier bits}
   logic [WIDTH:0]   mul_sum;
   logic [ACC_W-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: acc = {partial remainder, dividend bits becoming quotient bits}
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   div_diff;
   logic [ACC_W-1:0] div_next;

   assign rem_sh   = acc_q[ACC_W-1:WIDTH-1];
   assign div_diff = rem_sh - {1'b0, opb_q};
   assign div_next = div_diff[WIDTH]
                   ? {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   // Sign-corrected results presented during the fix-up cycle
   logic [ACC_W-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic             last_step;

   assign prod_fix  = neg_quo_q ? neg_acc(acc_q) : acc_q;
   assign quo_fix   = neg_quo_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   assign rem_fix   = neg_rem_q ? neg_w(acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   // Next-state and register-update logic; a new issue overrides whatever is in flight
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      is_div_d   = is_div_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         ST_MUL, ST_DIV: begin
            acc_d = (state_q == ST_MUL) ? mul_next : div_next;
            if (last_step) begin
               state_d = ST_FIX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = div_zero_q ? '1 : quo_fix;
            end else begin
               hi_d = prod_fix[ACC_W-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: ;
      endcase

      if (bus.start) begin
         case (bus.op)
            MULT, MULTU, DIV, DIVU: begin
               state_d    = op_div ? ST_DIV : ST_MUL;
               cnt_d      = '0;
               acc_d      = {WIDTH'(0), (op_div ? rs_abs : rt_abs)};
               opb_d      = op_div ? rt_abs : rs_abs;
               neg_quo_d  = op_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
               neg_rem_d  = op_signed && bus.rs_val[WIDTH-1];
               is_div_d   = op_div;
               div_zero_d = op_div && (bus.rt_val == '0);
               hi_d       = hi_q;
               lo_d       = lo_q;
               busy_d     = 1'b1;
               done_d     = 1'b0;
            end
            MTHI: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               hi_d    = bus.rs_val;
               lo_d    = lo_q;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
            MTLO: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               hi_d    = hi_q;
               lo_d    = bus.rs_val;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (clock_enable) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         is_div_q   <= is_div_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: issued ops push expected HI/LO and done cycle,
// a monitor pops and compares on each rising done pulse.
module tb_mips_cpu_muldiv;
   import mips_cpu_muldiv_pkg::*;

   localparam int unsigned W   = 32;
   localparam int          LAT = W + 2;

   logic clk          = 1'b0;
   logic reset_n      = 1'b0;
   logic clock_enable = 1'b1;

   mips_cpu_muldiv_if #(.WIDTH(W)) bus ();

   mips_cpu_muldiv #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .clock_enable (clock_enable),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
      int           tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one start strobe; optionally record the expected result and done cycle
   task automatic issue(input muldiv_op_t o, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input bit track, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int tag, input int extra);
      exp_t e;
      @(negedge clk);
      if (track) begin
         e.hi  = ehi;
         e.lo  = elo;
         e.cyc = cyc + LAT + extra;
         e.tag = tag;
         sb.push_back(e);
      end
      bus.start  = 1'b1;
      bus.op     = o;
      bus.rs_val = rs;
      bus.rt_val = rt;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (o inside {MULT, MULTU, DIV, DIVU})
         check($sformatf("busy_after_start tag=%0d", tag), 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("busy_timeout", 64'(bus.busy), 64'd0);
   endtask

   // Monitor: every new done pulse must match the head of the scoreboard
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done && !prev_done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
               e = sb.pop_front();
               check($sformatf("hi tag=%0d", e.tag), 64'(bus.hi), 64'(e.hi));
               check($sformatf("lo tag=%0d", e.tag), 64'(bus.lo), 64'(e.lo));
               check($sformatf("done_cycle tag=%0d", e.tag), 64'(cyc), 64'(e.cyc));
            end
         end
         prev_done = bus.done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start  = 1'b0;
      bus.op     = MULT;
      bus.rs_val = '0;
      bus.rt_val = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_hi",   64'(bus.hi),   64'd0);
      check("reset_lo",   64'(bus.lo),   64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      reset_n = 1'b1;

      // Signed multiply -3 * 7
      issue(MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 0);
      wait_idle(100);

      // Unsigned max * max; HI/LO must keep the previous result while busy
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 2, 0);
      repeat (5) @(negedge clk);
      check("hold_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      check("hold_lo", 64'(bus.lo), 64'hFFFF_FFEB);
      wait_idle(100);

      issue(DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 3, 0);
      wait_idle(100);
      issue(DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4, 0);
      wait_idle(100);
      issue(DIV, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 5, 0);
      wait_idle(100);
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 6, 0);
      wait_idle(100);
      issue(DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 7, 0);
      wait_idle(100);
      issue(DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 8, 0);
      wait_idle(100);

      // Reissue while busy: the first divide is abandoned
      issue(DIVU, 32'd100, 32'd7, 0, '0, '0, 90, 0);
      repeat (8) @(negedge clk);
      issue(MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, 9, 0);
      wait_idle(100);

      // MTHI while a divide is running: write HI, drop the divide, no done
      issue(DIV, 32'hFFFF_FFF9, 32'd2, 0, '0, '0, 91, 0);
      repeat (3) @(negedge clk);
      issue(MTHI, 32'h0000_00A5, 32'd0, 0, '0, '0, 92, 0);
      check("mthi_busy", 64'(bus.busy), 64'd0);
      check("mthi_hi",   64'(bus.hi),   64'h0000_00A5);
      check("mthi_lo",   64'(bus.lo),   64'd12);
      repeat (40) @(negedge clk);
      check("abort_hi_kept", 64'(bus.hi), 64'h0000_00A5);
      check("abort_lo_kept", 64'(bus.lo), 64'd12);
      issue(MTLO, 32'h0000_005A, 32'd0, 0, '0, '0, 93, 0);
      check("mtlo_lo", 64'(bus.lo), 64'h0000_005A);
      check("mtlo_hi", 64'(bus.hi), 64'h0000_00A5);

      // Four disabled cycles mid-operation stretch latency by exactly four
      issue(MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 10, 4);
      repeat (10) @(negedge clk);
      clock_enable = 1'b0;
      repeat (4) @(negedge clk);
      check("stall_busy", 64'(bus.busy), 64'd1);
      check("stall_hi",   64'(bus.hi),   64'h0000_00A5);
      clock_enable = 1'b1;
      wait_idle(100);

      // Asynchronous reset mid-multiply
      issue(MULT, 32'd1234, 32'd5678, 0, '0, '0, 94, 0);
      repeat (14) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("areset_hi",   64'(bus.hi),   64'd0);
      check("areset_lo",   64'(bus.lo),   64'd0);
      check("areset_busy", 64'(bus.busy), 64'd0);
      check("areset_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("areset_no_write_lo", 64'(bus.lo), 64'd0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
